// File: rtl/bcd_bin_if.sv
// Decoder-side bus for the BCD-to-binary converter: write strobe, chip
// select and packed BCD operand in; result and status out.
interface bcd_if;
  logic        bcdwrite;
  logic        bcdcs;
  logic [31:0] bcd_in;
  logic [26:0] binary;
  logic        busy;
  logic        done;
  logic        err;

  modport master (output bcdwrite, bcdcs, bcd_in,
                  input  binary, busy, done, err);
  modport slave  (input  bcdwrite, bcdcs, bcd_in,
                  output binary, busy, done, err);
endinterface

// File: rtl/bcd_bin.sv
// 8-digit packed BCD to 27-bit binary converter using reverse double-dabble:
// one right shift plus per-digit "subtract 3 if >= 8" per cycle, 27 cycles.

// Per-digit slice: correction of one shifted BCD field and range check of
// the matching input nibble.
module bcd_bin_dig (
  input  logic [3:0] sh,
  input  logic [3:0] nib,
  output logic [3:0] fix,
  output logic       bad
);
  assign fix = (sh >= 4'd8) ? sh - 4'd3 : sh;
  assign bad = (nib > 4'd9);
endmodule

module bcd_bin #(
  parameter int NUM_DIG = 8,
  parameter int BIN_W   = 27
) (
  input  logic    clk,
  input  logic    rst,
  bcd_if.slave    bus
);
  localparam int SR_W = 4*NUM_DIG + BIN_W;

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t                        state, state_d;
  logic [SR_W-1:0]               sr, sr_d, sr_sh, sr_corr;
  logic [4:0]                    cnt, cnt_d;
  logic [BIN_W-1:0]              bin, bin_d;
  logic                          err, err_d;
  logic                          done, done_d;
  logic                          inv, inv_d;
  logic [NUM_DIG-1:0][3:0]       fix;
  logic [NUM_DIG-1:0]            bad;

  assign sr_sh   = sr >> 1;
  assign sr_corr = {fix, sr_sh[BIN_W-1:0]};

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    bcd_bin_dig u_dig (
      .sh  (sr_sh[BIN_W + 4*i +: 4]),
      .nib (bus.bcd_in[4*i +: 4]),
      .fix (fix[i]),
      .bad (bad[i])
    );
  end

  // Next-state and datapath: accept in IDLE only, iterate in CONV, publish in FINISH
  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    bin_d   = bin;
    err_d   = err;
    done_d  = 1'b0;
    inv_d   = inv;
    case (state)
      IDLE: if (bus.bcdcs && bus.bcdwrite) begin
        if (|bad) begin
          // Bad digit: no conversion, report in FINISH with binary untouched
          inv_d   = 1'b1;
          state_d = FINISH;
        end else begin
          inv_d   = 1'b0;
          err_d   = 1'b0;
          sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = sr_corr;
        cnt_d = cnt + 5'd1;
        if (cnt == 5'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        err_d   = inv;
        if (!inv) bin_d = sr[BIN_W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion and zeroes results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bin   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      inv   <= 1'b0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      cnt   <= cnt_d;
      bin   <= bin_d;
      err   <= err_d;
      done  <= done_d;
      inv   <= inv_d;
    end
  end

  assign bus.binary = bin;
  assign bus.err    = err;
  assign bus.done   = done;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_bcd_bin.sv
// Directed bench for bcd_bin: latency, results, error path, ignored
// requests, mid-conversion reset and back-to-back operation.
module tb_bcd_bin;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_if bus ();

  bcd_bin dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Called at a negedge: present one request for exactly one rising edge.
  task automatic issue(input logic [31:0] d);
    bus.bcd_in   = d;
    bus.bcdcs    = 1'b1;
    bus.bcdwrite = 1'b1;
    @(negedge clk);
    bus.bcdcs    = 1'b0;
    bus.bcdwrite = 1'b0;
    bus.bcd_in   = 32'hFFFF_FFFF;
  endtask

  // Cycles (negedges after the request edge) until done; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.binary !== 27'd0) begin errors++; $display("FAIL reset_binary got %0d want 0", bus.binary); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_2021;
    int lat = -1;
    int busy_bad = 0;
    issue(32'h0000_2021);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin lat = k; break; end
      if (bus.busy !== 1'b1) busy_bad++;
    end
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_2021 got %0d want 28", lat); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_2021 low_cycles %0d want 0", busy_bad); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", bus.busy); end
    checks++; if (bus.binary !== 27'd2021) begin errors++; $display("FAIL bin_2021 got %0d want 2021", bus.binary); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_2021 got %b want 0", bus.err); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", bus.done); end
  endtask

  task automatic test_extremes;
    int lat;
    issue(32'h0000_0000);
    wait_done(lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_zero got %0d want 28", lat); end
    checks++; if (bus.binary !== 27'd0) begin errors++; $display("FAIL bin_zero got %0d want 0", bus.binary); end
    @(negedge clk);
    issue(32'h9999_9999);
    wait_done(lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_max got %0d want 28", lat); end
    checks++; if (bus.binary !== 27'd99_999_999) begin errors++; $display("FAIL bin_max got %0d want 99999999", bus.binary); end
    @(negedge clk);
  endtask

  task automatic test_invalid;
    int lat;
    issue(32'h0000_001A);
    wait_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lat_invalid got %0d want 1", lat); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_invalid got %b want 1", bus.err); end
    checks++; if (bus.binary !== 27'd99_999_999) begin errors++; $display("FAIL bin_kept got %0d want 99999999", bus.binary); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b1) begin errors++; $display("FAIL invalid_after done=%b err=%b want 0 1", bus.done, bus.err); end
    issue(32'h0000_0010);
    wait_done(lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_ten got %0d want 28", lat); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", bus.err); end
    checks++; if (bus.binary !== 27'd10) begin errors++; $display("FAIL bin_ten got %0d want 10", bus.binary); end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    int first = -1;
    int ndone = 0;
    issue(32'h0000_1234);
    repeat (9) @(negedge clk);
    issue(32'h0000_0005);
    for (int k = 11; k <= 45; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (first < 0) first = k;
      end
      if (k == 28) begin
        checks++; if (bus.binary !== 27'd1234) begin errors++; $display("FAIL bin_ignore got %0d want 1234", bus.binary); end
      end
    end
    checks++; if (first !== 28) begin errors++; $display("FAIL lat_ignore got %0d want 28", first); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL done_count got %0d want 1", ndone); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int ndone = 0;
    issue(32'h0000_1234);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.binary !== 27'd0) begin errors++; $display("FAIL mid_binary got %0d want 0", bus.binary); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.done) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0 || bus.binary !== 27'd0) begin errors++; $display("FAIL mid_nodone dones=%0d bin=%0d want 0 0", ndone, bus.binary); end
    // request on the first edge after release of a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(32'h0000_0042);
    wait_done(lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_post_rst got %0d want 28", lat); end
    checks++; if (bus.binary !== 27'd42) begin errors++; $display("FAIL bin_post_rst got %0d want 42", bus.binary); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(32'h0000_0001);
    wait_done(lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_b2b1 got %0d want 28", lat); end
    checks++; if (bus.binary !== 27'd1) begin errors++; $display("FAIL bin_b2b1 got %0d want 1", bus.binary); end
    issue(32'h0012_3456);
    wait_done(lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL lat_b2b2 got %0d want 28", lat); end
    checks++; if (bus.binary !== 27'd123456) begin errors++; $display("FAIL bin_b2b2 got %0d want 123456", bus.binary); end
    @(negedge clk);
  endtask

  initial begin
    bus.bcdwrite = 1'b0;
    bus.bcdcs    = 1'b0;
    bus.bcd_in   = 32'h0;
    @(negedge clk);
    test_reset;
    test_2021;
    test_extremes;
    test_invalid;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_bin.md
BCD_BIN -- requirements
Module: bcd_bin

Interface
- REQ-001 SHALL have a single clock and an asynchronous, active-high reset: clk is the only clock, and rst is asynchronous and active-high.
- REQ-002 SHALL provide port clk, input, 1 bit: system clock; all state updates on its rising edge.
- REQ-003 SHALL provide port rst, input, 1 bit: asynchronous active-high reset.
- REQ-004 SHALL provide port bcdwrite, input, 1 bit: write strobe from the memory/IO decoder.
- REQ-005 SHALL provide port bcdcs, input, 1 bit: chip select for this block from the memory/IO decoder.
- REQ-006 SHALL provide port bcd_in, input, 32 bits: 8 packed BCD digits; [31:28] is the most significant digit, [3:0] the least.
- REQ-007 SHALL provide port binary, output, 27 bits: converted unsigned value (maximum 99_999_999 < 2^27).
- REQ-008 SHALL provide port busy, output, 1 bit: high while a conversion is in progress.
- REQ-009 SHALL provide port done, output, 1 bit: single-cycle completion pulse.
- REQ-010 SHALL provide port err, output, 1 bit: last request contained a nibble > 9.

Function
- REQ-011 SHALL implement an FSM with states IDLE, CONV and FINISH.
- REQ-012 SHALL define a request as bcdcs && bcdwrite sampled high on a rising edge while in IDLE.
- REQ-013 SHALL ignore requests in CONV or FINISH: no queuing, no restart.
- REQ-014 SHALL, on a valid request (all nibbles <= 9):
  - load the 59-bit shift register with {bcd_in, 27'b0};
  - clear the iteration counter;
  - go to CONV and assert busy.
- REQ-015 SHALL, on each CONV cycle:
  - shift the whole 59-bit register right by 1;
  - then, for each of the 8 upper 4-bit digit fields independently, subtract 3 if the field is >= 8;
  - increment the counter.
- REQ-016 SHALL perform exactly 27 CONV iterations; after the 27th, go to FINISH.
- REQ-017 SHALL, in FINISH:
  - load binary from the low 27 bits of the shift register;
  - assert done for exactly one cycle;
  - deassert busy;
  - return to IDLE.
- REQ-018 SHALL give a latency of 28 cycles for a valid request: with the request edge at N, binary is updated and done is high after edge N+28; busy is high from edge N to edge N+27 inclusive.
- REQ-019 SHALL, on an invalid request (any nibble > 9):
  - skip CONV and go directly to FINISH;
  - set err = 1, leave binary unchanged, and pulse done one cycle later.
- REQ-020 SHALL clear err on the next accepted valid request and update it at every FINISH.
- REQ-021 SHALL hold binary and err stable between FINISH events, independent of bcd_in, bcdcs and bcdwrite.
- REQ-022 SHALL make a request in the cycle immediately after done eligible for acceptance (back-to-back operation, with IDLE lasting at least one cycle).
- REQ-023 SHALL compute all arithmetic unsigned and zero-extend the result; no overflow is possible.

Reset
- REQ-024 SHALL, while rst is high and regardless of clk, force:
  - state = IDLE;
  - binary = 0, busy = 0, done = 0, err = 0;
  - shift register and counter = 0.
- REQ-025 SHALL, on reset asserted mid-conversion, abort the conversion with no done pulse and leave binary at 0.
- REQ-026 SHALL accept the first request on the first rising edge after rst deasserts.

Verification
- REQ-027 SHALL check: bcd_in=32'h0000_2021 request -> after 28 cycles binary=27'd2021 (0x7E5), done pulses 1 cycle, err=0.
- REQ-028 SHALL check: bcd_in=32'h9999_9999 -> binary=27'd99_999_999 (0x5F5_E0FF); bcd_in=32'h0000_0000 -> binary=0, done pulses.
- REQ-029 SHALL check: bcd_in=32'h0000_001A -> done pulses 1 cycle after the request, err=1, binary keeps its previous value; a following 32'h0000_0010 -> err=0, binary=10.
- REQ-030 SHALL check: a second request with 32'h0000_0005 issued 10 cycles into a 32'h0000_1234 conversion -> ignored; result 1234 at cycle 28, and only one done pulse.
- REQ-031 SHALL check: rst asserted at cycle 15 of a conversion -> immediately busy=0, binary=0, no done; a new request after release converts correctly.
- REQ-032 SHALL check: back-to-back requests 32'h0000_0001 then 32'h0012_3456, the second asserted the cycle after done -> binary=1, then binary=123456.
